// File: rtl/cache_pkg.sv
// Shared cache definitions: fill FSM state encoding and block geometry.
package cache_pkg;

  typedef enum logic {
    FILL_IDLE = 1'b0,
    FILL_BUSY = 1'b1
  } fill_state_t;

  localparam int WORDS_PER_BLOCK_DEF = 8;
  localparam int BLOCK_OFFSET_BITS   = 4;
  localparam int WORD_SEL_BITS       = 3;

  // Clear the byte-offset bits of an address to get its block base.
  function automatic logic [15:0] block_base16(input logic [15:0] addr);
    return addr & ~((16'd1 << BLOCK_OFFSET_BITS) - 16'd1);
  endfunction

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Miss/fill bus between the cache lookup, main memory and the fill FSM.
// Optional feature macro: CACHE_FILL_PERF_CNT_EN adds fill_count.
interface cache_fill_fsm_if #(
  parameter int ADDR_WIDTH      = 16,
  parameter int WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK_DEF
);
  localparam int SEL_W = $clog2(WORDS_PER_BLOCK);

  logic                  miss_detected;
  logic [ADDR_WIDTH-1:0] miss_address;
  logic                  memory_data_valid;
  logic                  fsm_busy;
  logic                  write_data_array;
  logic                  write_tag_array;
  logic [SEL_W-1:0]      data_word_sel;
  logic [ADDR_WIDTH-1:0] memory_address;
  logic                  memory_enable;
`ifdef CACHE_FILL_PERF_CNT_EN
  logic [15:0]           fill_count;
`endif

  // Cache/memory side driving the controller.
  modport master (
`ifdef CACHE_FILL_PERF_CNT_EN
    input  fill_count,
`endif
    output miss_detected, miss_address, memory_data_valid,
    input  fsm_busy, write_data_array, write_tag_array, data_word_sel,
           memory_address, memory_enable
  );

  // The fill controller itself.
  modport slave (
`ifdef CACHE_FILL_PERF_CNT_EN
    output fill_count,
`endif
    input  miss_detected, miss_address, memory_data_valid,
    output fsm_busy, write_data_array, write_tag_array, data_word_sel,
           memory_address, memory_enable
  );

endinterface

// File: rtl/fill_counter.sv
// Up-counter with synchronous clear, count enable and terminal-count flag.
module fill_counter #(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] TC_VALUE = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  // Count register: reset/clear win over enable.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) count <= '0;
    else if (en)    count <= count + WIDTH'(1);
  end

  assign tc = (count == TC_VALUE);

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: issues WORDS_PER_BLOCK sequential word reads,
// steers returning words into the data array and writes the tag on the last.
// Optional feature macro: CACHE_FILL_PERF_CNT_EN adds a saturating fill_count.
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH      = 16,
  parameter int WORDS_PER_BLOCK = WORDS_PER_BLOCK_DEF
) (
  input logic             clk,
  input logic             rst,
  cache_fill_fsm_if.slave bus
);

  localparam int SEL_W    = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_W    = SEL_W + 1;
  localparam int OFF_BITS = $clog2(2 * WORDS_PER_BLOCK);
  localparam logic [ADDR_WIDTH-1:0] BASE_MASK =
    ~((ADDR_WIDTH'(1) << OFF_BITS) - ADDR_WIDTH'(1));
  localparam logic [CNT_W-1:0] REQ_TC = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0] RCV_TC = CNT_W'(WORDS_PER_BLOCK - 1);

  fill_state_t           state, state_nxt;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [CNT_W-1:0]      req_cnt, rcv_cnt;
  logic                  req_tc, rcv_tc;
  logic                  busy, start, req_en, rcv_en, last;

  assign busy   = (state == FILL_BUSY);
  assign start  = (state == FILL_IDLE) && bus.miss_detected;
  assign req_en = busy && !req_tc;
  // The receive side is independent of req_cnt so valids may run ahead.
  assign rcv_en = busy && bus.memory_data_valid;
  assign last   = rcv_en && rcv_tc;

  fill_counter #(.WIDTH(CNT_W), .TC_VALUE(REQ_TC)) u_req_cnt (
    .clk(clk), .rst(rst), .clr(start), .en(req_en), .count(req_cnt), .tc(req_tc)
  );

  fill_counter #(.WIDTH(CNT_W), .TC_VALUE(RCV_TC)) u_rcv_cnt (
    .clk(clk), .rst(rst), .clr(start), .en(rcv_en), .count(rcv_cnt), .tc(rcv_tc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= FILL_IDLE;
    else     state <= state_nxt;
  end

  // Latch the block base when a fill starts; later address changes are ignored.
  always_ff @(posedge clk) begin
    if (rst)        base_q <= '0;
    else if (start) base_q <= bus.miss_address & BASE_MASK;
  end

  // Next-state and output decode; every output is forced low while in reset.
  // NOTE: all always_comb targets get a default first so no latch is inferred.
  always_comb begin
    state_nxt            = state;
    bus.fsm_busy         = 1'b0;
    bus.memory_enable    = 1'b0;
    bus.memory_address   = '0;
    bus.write_data_array = 1'b0;
    bus.write_tag_array  = 1'b0;
    bus.data_word_sel    = '0;

    case (state)
      FILL_IDLE: if (bus.miss_detected) state_nxt = FILL_BUSY;
      FILL_BUSY: if (last)              state_nxt = FILL_IDLE;
      default:                          state_nxt = FILL_IDLE;
    endcase

    if (!rst) begin
      bus.fsm_busy         = busy || start;
      bus.memory_enable    = req_en;
      // Offset bits are zero in the base, so OR never carries into the index.
      bus.memory_address   = busy ? (base_q | (ADDR_WIDTH'(req_cnt) << 1)) : '0;
      bus.write_data_array = rcv_en;
      bus.data_word_sel    = busy ? rcv_cnt[SEL_W-1:0] : '0;
      bus.write_tag_array  = last;
    end
  end

`ifdef CACHE_FILL_PERF_CNT_EN
  logic [15:0] fill_cnt_q;

  // Completed-fill counter, saturating at all ones.
  always_ff @(posedge clk) begin
    if (rst)                              fill_cnt_q <= '0;
    else if (last && (fill_cnt_q != '1))  fill_cnt_q <= fill_cnt_q + 16'd1;
  end

  assign bus.fill_count = fill_cnt_q;
`endif

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with a scoreboard of expected request
// addresses and word slots, plus a small behavioural memory model.
module tb_cache_fill_fsm;

  logic clk;
  logic rst;

  cache_fill_fsm_if #(.ADDR_WIDTH(16), .WORDS_PER_BLOCK(8)) bus ();

  cache_fill_fsm #(.ADDR_WIDTH(16), .WORDS_PER_BLOCK(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Memory model and reference model state.
  int          cyc = 0;
  int          t0  = 0;
  int          lat = 4;       // -1: valids driven directly by the test
  int          due[$];
  logic [15:0] exp_addr[$];
  logic [2:0]  exp_sel[$];
  logic        m_busy = 1'b0;
  int          m_req  = 0;
  int          m_rcv  = 0;
  logic [15:0] m_base;
  bit          tag_log  [64];
  bit          busy_log [64];
  bit          wd_log   [64];
  int          tag_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s @rel %0d: observed %h expected %h", tag, cyc - t0, obs, exp);
    end
  endtask

  task automatic begin_test(input int latency);
    lat = latency;
    t0  = cyc;
    tag_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      tag_log[i] = 0; busy_log[i] = 0; wd_log[i] = 0;
    end
  endtask

  // One clock cycle: drive inputs on the falling edge, let the memory model
  // respond, compare all outputs, then advance the reference model.
  task automatic step(input logic r, input logic miss, input logic [15:0] maddr,
                      input logic fv);
    logic v, e_en, e_wd, e_tag, e_busy;
    int   rel;
    @(negedge clk);
    rst = r;
    bus.miss_detected = miss;
    bus.miss_address  = maddr;
    v = fv;
    if (due.size() > 0 && due[0] == cyc) begin
      v = 1'b1;
      void'(due.pop_front());
    end
    bus.memory_data_valid = v;
    #1;
    if (bus.memory_enable === 1'b1) begin
      if (lat == 0) begin
        v = 1'b1;
        bus.memory_data_valid = 1'b1;
        #1;
      end else if (lat > 0) begin
        due.push_back(cyc + lat);
      end
    end

    e_en   = !r && m_busy && (m_req < 8);
    e_wd   = !r && m_busy && v;
    e_tag  = e_wd && (m_rcv == 7);
    e_busy = !r && (m_busy || miss);

    check("memory_enable", 32'(bus.memory_enable), 32'(e_en));
    if (e_en) check("memory_address", 32'(bus.memory_address), 32'(exp_addr.pop_front()));
    check("write_data_array", 32'(bus.write_data_array), 32'(e_wd));
    if (e_wd) check("data_word_sel", 32'(bus.data_word_sel), 32'(exp_sel.pop_front()));
    check("write_tag_array", 32'(bus.write_tag_array), 32'(e_tag));
    check("fsm_busy", 32'(bus.fsm_busy), 32'(e_busy));
    if (r) begin
      check("rst memory_address", 32'(bus.memory_address), 32'd0);
      check("rst data_word_sel", 32'(bus.data_word_sel), 32'd0);
    end

    rel = cyc - t0;
    if (rel >= 0 && rel < 64) begin
      tag_log[rel]  = (bus.write_tag_array === 1'b1);
      busy_log[rel] = (bus.fsm_busy === 1'b1);
      wd_log[rel]   = (bus.write_data_array === 1'b1);
    end
    if (bus.write_tag_array === 1'b1) tag_cnt++;

    if (r) begin
      m_busy = 1'b0; m_req = 0; m_rcv = 0;
      exp_addr.delete(); exp_sel.delete();
    end else if (m_busy) begin
      if (e_en) m_req++;
      if (e_wd) m_rcv++;
      if (e_tag) m_busy = 1'b0;
    end else if (miss) begin
      m_busy = 1'b1; m_req = 0; m_rcv = 0;
      m_base = maddr & 16'hFFF0;
      for (int i = 0; i < 8; i++) begin
        exp_addr.push_back(m_base | 16'(i * 2));
        exp_sel.push_back(3'(i));
      end
    end
    cyc++;
  endtask

  initial begin
    logic [15:0] a;
    rst = 1'b1;
    bus.miss_detected     = 1'b0;
    bus.miss_address      = '0;
    bus.memory_data_valid = 1'b0;

    // Reset state, then a few idle cycles.
    begin_test(4);
    step(1, 0, 16'h0000, 0);
    step(1, 1, 16'h1234, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 16'h0000, 0);
`ifdef CACHE_FILL_PERF_CNT_EN
    check("fill_count reset", 32'(bus.fill_count), 32'd0);
`endif

    // Basic fill, 4-cycle memory.
    begin_test(4);
    step(0, 1, 16'h1236, 0);
    for (int i = 1; i < 16; i++) step(0, 0, 16'h0000, 0);
    check("basic wd@4", 32'(wd_log[4]), 32'd0);
    check("basic wd@5", 32'(wd_log[5]), 32'd1);
    check("basic tag@12", 32'(tag_log[12]), 32'd1);
    check("basic busy@12", 32'(busy_log[12]), 32'd1);
    check("basic busy@13", 32'(busy_log[13]), 32'd0);
    check("basic tag count", 32'(tag_cnt), 32'd1);
    check("basic addr drained", 32'(exp_addr.size()), 32'd0);
    check("basic sel drained", 32'(exp_sel.size()), 32'd0);

    // Zero-latency memory at the top of the address space.
    begin_test(0);
    step(0, 1, 16'hFFFE, 0);
    for (int i = 1; i < 12; i++) step(0, 0, 16'h0000, 0);
    check("zl tag@8", 32'(tag_log[8]), 32'd1);
    check("zl busy@8", 32'(busy_log[8]), 32'd1);
    check("zl busy@9", 32'(busy_log[9]), 32'd0);
    check("zl tag count", 32'(tag_cnt), 32'd1);

    // Spurious valids: while idle and a 9th after the tag write.
    begin_test(4);
    for (int i = 0; i < 3; i++) step(0, 0, 16'h0000, 1);
    begin_test(4);
    step(0, 1, 16'h2000, 0);
    for (int i = 1; i < 16; i++) step(0, 0, 16'h0000, (i == 13 || i == 14));
    check("spur tag count", 32'(tag_cnt), 32'd1);
    check("spur wd@13", 32'(wd_log[13]), 32'd0);

    // Reset in the middle of a fill; in-flight words arrive afterwards.
    begin_test(4);
    step(0, 1, 16'h3456, 0);
    for (int i = 1; i < 6; i++) step(0, 0, 16'h0000, 0);
    step(1, 0, 16'h0000, 0);
    for (int i = 7; i < 14; i++) step(0, 0, 16'h0000, 0);
    check("rstmid busy@7", 32'(busy_log[7]), 32'd0);
    check("rstmid wd@7", 32'(wd_log[7]), 32'd0);
    check("rstmid tag count", 32'(tag_cnt), 32'd0);
`ifdef CACHE_FILL_PERF_CNT_EN
    check("fill_count after rst", 32'(bus.fill_count), 32'd0);
`endif

    // Back-to-back misses with miss_detected held high.
    begin_test(4);
    for (int i = 0; i < 30; i++) begin
      if (i < 3)       a = 16'h1238;
      else if (i < 13) a = 16'hBEEF;
      else             a = 16'h4568;
      step(0, (i <= 13), a, 0);
    end
    check("b2b tag@12", 32'(tag_log[12]), 32'd1);
    check("b2b busy@13", 32'(busy_log[13]), 32'd1);
    check("b2b tag@25", 32'(tag_log[25]), 32'd1);
    check("b2b busy@26", 32'(busy_log[26]), 32'd0);
    check("b2b tag count", 32'(tag_cnt), 32'd2);
`ifdef CACHE_FILL_PERF_CNT_EN
    check("fill_count b2b", 32'(bus.fill_count), 32'd2);
`endif

    // Gapped data return: a valid every third cycle.
    begin_test(-1);
    step(0, 1, 16'h5552, 0);
    for (int i = 1; i < 27; i++) step(0, 0, 16'h0000, (i % 3 == 1) && (i <= 22));
    check("gap tag@22", 32'(tag_log[22]), 32'd1);
    check("gap busy@21", 32'(busy_log[21]), 32'd1);
    check("gap busy@23", 32'(busy_log[23]), 32'd0);
    check("gap tag count", 32'(tag_cnt), 32'd1);
    check("gap sel drained", 32'(exp_sel.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
    $finish;
  end

endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling controller between the L1 caches and the multi-cycle main memory. On a cache miss it fetches the whole 16-byte block as 8 sequential 16-bit word reads and steers each returning word into the cache data array. It also writes the tag array on the final word and stalls the pipeline through `fsm_busy` until the fill completes. One instance serves the I-cache and one serves the D-cache; arbitration between them lives outside this block.

## Interface
- `ADDR_WIDTH`, 16, byte-address width.
- `WORDS_PER_BLOCK`, 8, 16-bit words per cache block; must be a power of two, ≥2.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `miss_detected` in 1: cache lookup missed this cycle.
- `miss_address` in ADDR_WIDTH: byte address that missed.
- `memory_data_valid` in 1: memory is returning one read word this cycle.
- `fsm_busy` out 1: stall request to the pipeline.
- `write_data_array` out 1: write the returning memory word into the data array.
- `write_tag_array` out 1: write the tag and valid bit for the block.
- `data_word_sel` out log2(WORDS_PER_BLOCK): word slot within the block for the current data-array write.
- `memory_address` out ADDR_WIDTH: read address presented to memory.
- `memory_enable` out 1: memory read request; the write strobe is tied 0 externally.

## Operation
- Two states: `FILL_IDLE` and `FILL_BUSY`.
- Block base: `miss_address` with the low log2(2·WORDS_PER_BLOCK) bits zeroed. It is latched on entry to `FILL_BUSY`.
- Two counters, each 0..WORDS_PER_BLOCK:
  - `req_cnt` counts issued requests.
  - `rcv_cnt` counts received words.
- **IDLE → BUSY:** when `miss_detected`=1 in `FILL_IDLE`. Both counters clear.
- **BUSY, request side:**
  - `memory_enable` = (`req_cnt` < WORDS_PER_BLOCK).
  - `memory_address` = base | (`req_cnt`·2). Only the offset bits change, so there is no carry into the tag or index and no wrap.
  - `req_cnt` increments each cycle `memory_enable`=1. One request is issued per cycle, back-to-back, with no backpressure.
- **BUSY, receive side:**
  - `write_data_array` = `memory_data_valid`.
  - `data_word_sel` = `rcv_cnt`.
  - `rcv_cnt` increments on each valid.
- **BUSY → IDLE:** on the cycle of the last valid (`rcv_cnt` = WORDS_PER_BLOCK−1 with `memory_data_valid`=1), `write_tag_array`=1 for that single cycle. The state returns to `FILL_IDLE` the next cycle.
- `fsm_busy` = (state==`FILL_BUSY`) | (state==`FILL_IDLE` & `miss_detected`). It is high in the detecting cycle, so the pipeline never advances past a miss.
- **Ignored inputs:**
  - `memory_data_valid` in `FILL_IDLE` is ignored, as are valids beyond WORDS_PER_BLOCK.
  - `miss_detected` in `FILL_BUSY` is ignored.
  - `miss_address` changes after the latch are ignored.
- **Back-to-back misses:** if `miss_detected` is high in the first `FILL_IDLE` cycle after a fill, a new fill starts. This is legal; the cache normally hits because the tag was written.
- Valids may arrive before all requests are issued. The receive side never depends on `req_cnt`.

## Timing
- Reset values, applied the cycle after `rst` is sampled high:
  - state `FILL_IDLE`; `req_cnt` and `rcv_cnt` 0; latched base 0.
  - All outputs 0 while `rst`=1, including the combinational ones.
- Reset mid-fill: the fill aborts with no tag write. Memory words still in flight are dropped as idle-state valids.
- Worked example with a 4-cycle memory latency and WORDS_PER_BLOCK=8:
  - Miss seen at cycle 0.
  - Requests issued cycles 1–8.
  - Valids arrive cycles 5–12.
  - Tag written at cycle 12.
  - `fsm_busy` is high cycles 0–12 and low at cycle 13.
- Minimum fill, with a combinational memory (valid in the same cycle as the request): miss at 0, requests and data at 1–8, `fsm_busy` low at cycle 9.

## Configuration
- `CACHE_FILL_PERF_CNT_EN` defined:
  - Adds output `fill_count`, 16 bits.
  - Increments on every `write_tag_array` pulse.
  - Saturates at 0xFFFF; reset value 0.
- Undefined: the port and the counter are absent, and the rest of the behaviour is identical.

## Structure
- Shared package `cache_pkg`:
  - Enum `fill_state_t` {`FILL_IDLE`, `FILL_BUSY`}.
  - Constants `WORDS_PER_BLOCK_DEF`=8, `BLOCK_OFFSET_BITS`=4, `WORD_SEL_BITS`=3.
- Sub-module `fill_counter`: parameterised width, with synchronous clear, enable and terminal-count flag. It is instantiated twice, for `req_cnt` and `rcv_cnt`.

## Test plan
- **Basic fill:** miss at 0x1236, 4-cycle memory model.
  - Addresses 0x1230, 0x1232 … 0x123E on cycles 1–8.
  - `data_word_sel` 0–7 on cycles 5–12.
  - Single `write_tag_array` at cycle 12; `fsm_busy` low at cycle 13.
- **Zero-latency memory:** miss at 0xFFFE.
  - Requests 0xFFF0–0xFFFE with no wrap into 0x0000.
  - Tag write at cycle 8.
- **Spurious valids:** valid pulses while idle and a 9th valid after the tag write.
  - No `write_data_array` or `write_tag_array` for either.
- **Reset mid-fill:** `rst` at cycle 6.
  - Outputs 0 and state idle at cycle 7.
  - No tag write; late valids ignored.
- **Back-to-back misses:** `miss_detected` held high across a fill completion.
  - Second fill starts at cycle 13 with the new base.
  - With `CACHE_FILL_PERF_CNT_EN`, `fill_count`=2 after both.
- **Irregular data return:** gapped valids (every 3rd cycle).
  - Word slots stay in order 0–7.
  - `fsm_busy` is held high until the 8th valid.
